// File: rtl/nibble_serial_subtractor.sv
// Serial WIDTH-bit subtractor: diff = a - b - borrowin, one nibble per clock,
// LSB nibble first, with valid/ready handshakes on both the operand and result sides.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       step;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bin_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bin_q   <= bin_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  // The operand registers shift right so the active nibble is always at [3:0];
  // result nibbles enter from the MSB end so nibble 0 lands at the bottom.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bin_d   = bin_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    step    = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, bin_q};
    shifted = {step[3:0], res_q[WIDTH-1:4]};

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          bin_d   = borrowin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        res_d = shifted;
        bin_d = step[4];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NIB - 1)) begin
          diff_d  = shifted;
          bout_d  = step[4];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = rst && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrowout = bout_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: vector table, backpressure,
// mid-run reset and back-to-back random traffic against a full-width model.
module tb_nibble_serial_subtractor;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             borrowin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             borrowout;

  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .borrowin (borrowin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrowout(borrowout)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bo;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] expDiff;
    logic             expBo;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[10];
  int   assertCount = 0;
  int   failCount = 0;
  int   acceptCnt = 0;

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    logic [WIDTH:0] r;
    r = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
    return '{diff: r[WIDTH-1:0], bo: r[WIDTH]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                               input logic tbin, input exp_t e);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb;
    borrowin = tbin;
    in_valid = 1'b1;
    sbQ.push_back(e);
    @(negedge clk);
    acceptCnt = cycleCnt;
    in_valid  = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_latency"}, 32'(cycleCnt - acceptCnt), 32'(NIB));
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    waitValid(name);
    check({name, "_sb_nonempty"}, 32'(sbQ.size() > 0), 32'd1);
    e = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
    check({name, "_diff"}, 32'(diff), 32'(e.diff));
    check({name, "_borrowout"}, 32'(borrowout), 32'(e.bo));
    check({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_cleared"}, 32'(out_valid), 32'd0);
    check({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    logic sawValid;
    int   nAcc, prevAcc, guard;
    logic havePrev, accNow;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vecs[7] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vecs[8] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
    vecs[9] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_borrowout", 32'(borrowout), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, '{diff: vecs[i].expDiff, bo: vecs[i].expBo});
      checkOutput($sformatf("vec%0d", i));
    end

    // Backpressure: result must stay frozen while inputs churn.
    applyStimulus(16'h1234, 16'hABCD, 1'b0, '{diff: 16'h6667, bo: 1'b1});
    waitValid("bp");
    e = sbQ.pop_front();
    for (int i = 0; i < 10; i++) begin
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      borrowin = 1'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_diff", 32'(diff), 32'(e.diff));
      check("bp_borrowout", 32'(borrowout), 32'(e.bo));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Reset while the third nibble is being processed.
    applyStimulus(16'h1234, 16'h0001, 1'b0, model(16'h1234, 16'h0001, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    void'(sbQ.pop_back());
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrowout", 32'(borrowout), 32'd0);
    check("midrst_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready_high", 32'(in_ready), 32'd1);
    sawValid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      sawValid |= out_valid;
    end
    check("midrst_no_valid_pulse", 32'(sawValid), 32'd0);
    applyStimulus(16'h0003, 16'h0001, 1'b0, '{diff: 16'h0002, bo: 1'b0});
    checkOutput("midrst_fresh");

    // Back-to-back random traffic with both handshakes held open.
    out_ready = 1'b1;
    nAcc      = 0;
    prevAcc   = 0;
    havePrev  = 1'b0;
    guard     = 0;
    a         = WIDTH'($urandom);
    b         = WIDTH'($urandom);
    borrowin  = 1'($urandom);
    in_valid  = 1'b1;
    sbQ.push_back(model(a, b, borrowin));
    while ((nAcc < 100 || sbQ.size() > 0) && guard < 3000) begin
      if (out_valid) begin
        e = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
        check("b2b_diff", 32'(diff), 32'(e.diff));
        check("b2b_borrowout", 32'(borrowout), 32'(e.bo));
      end
      accNow = in_ready && in_valid;
      if (accNow) begin
        if (havePrev) check("b2b_accept_gap", 32'(cycleCnt - prevAcc), 32'(NIB + 2));
        prevAcc  = cycleCnt;
        havePrev = 1'b1;
        nAcc++;
      end
      @(posedge clk);
      #1;
      if (accNow) begin
        if (nAcc < 100) begin
          a        = WIDTH'($urandom);
          b        = WIDTH'($urandom);
          borrowin = 1'($urandom);
          sbQ.push_back(model(a, b, borrowin));
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    check("b2b_accept_count", 32'(nAcc), 32'd100);
    check("b2b_sb_drained", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Multi-cycle WIDTH-bit subtractor that computes diff = a - b - borrowin four bits per clock, least-significant nibble first, through a registered borrow chain. It is the inverse arithmetic path to the team's registered 4-bit adder and reuses the same 4-bit datapath width. Operands enter and results leave on valid/ready handshakes, so the block can sit between pipeline stages that may stall.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8
NIB (derived, not overridable), WIDTH/4, number of nibble steps per operation

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  operand offer
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
borrowin  input  1  borrow into bit 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
diff  output  WIDTH  result a - b - borrowin, modulo 2^WIDTH
borrowout  output  1  1 when a < b + borrowin, unsigned

Behaviour:
- Reset: rst is synchronous and active-low; clk is the clock. When rst=0 at a rising edge: state=IDLE, out_valid=0, diff=0, borrowout=0, and internal operand, shift and borrow registers=0. in_ready is forced to 0 while rst=0.
- FSM states:
  - IDLE: in_ready=1. An accept occurs at an edge with in_valid=1 and in_ready=1. On accept, latch a, b and borrowin, clear the step counter, and go to RUN.
  - RUN: in_ready=0. Each edge performs step k (k=0..NIB-1) on nibble k:
    - {bo, d} = {1'b0, a_k} - {1'b0, b_k} - bin, using 5-bit arithmetic.
    - bin for step 0 is the latched borrowin; for later steps it is bo from the previous step.
    - d is shifted into the result register from the MSB end.
    - After step NIB-1, load diff from the result register, set borrowout=bo, set out_valid=1, and go to DONE.
  - DONE: in_ready=0; out_valid=1; diff and borrowout are held stable. At an edge with out_ready=1, clear out_valid and go to IDLE.
- Latency: out_valid rises exactly NIB edges after the accepting edge (4 for WIDTH=16).
- Throughput and overlap:
  - A new accept is possible no earlier than the edge after the result handshake.
  - Peak rate is one operation per NIB+2 cycles.
  - No overlap: in_valid is ignored outside IDLE.
- Input stability: a, b and borrowin are sampled only at the accepting edge. Changes during RUN or DONE have no effect.
- Backpressure: out_ready=0 in DONE holds all outputs indefinitely, with no loss or corruption of the result.
- out_ready outside DONE is ignored.
- diff and borrowout retain the last result after the handshake until the next completion overwrites them. Consumers use them only while out_valid=1.
- Wrap-around: the result is modulo 2^WIDTH. borrowout=1 exactly when the unsigned true result is negative, including the case 0 - 0 - 1.
- Reset mid-operation: rst=0 in RUN or DONE aborts the operation. All rules above apply on that edge, and no out_valid pulse is produced.
- Arithmetic is unsigned. The signed-overflow flag is out of scope.

Test Plan:
- Basic: WIDTH=16, a=0x1234, b=0x0234, borrowin=0 -> 4 edges after accept, out_valid=1, diff=0x1000, borrowout=0.
- Full borrow ripple: a=0x0000, b=0x0001, borrowin=0 -> diff=0xFFFF, borrowout=1. Also a=0x8000, b=0x0001 -> diff=0x7FFF, borrowout=0.
- Borrowin: a=0x0005, b=0x0005, borrowin=1 -> diff=0xFFFF, borrowout=1. Also a=0xFFFF, b=0x0000, borrowin=1 -> diff=0xFFFE, borrowout=0.
- Backpressure and stability:
  - Hold out_ready=0 for 10 cycles in DONE while toggling a, b and in_valid -> out_valid stays 1, diff and borrowout stay unchanged, in_ready=0.
  - Then out_ready=1 -> IDLE on the next edge.
- Reset mid-run: accept 0x1234-0x0001, drive rst=0 at step 2 -> next edge out_valid=0, diff=0, borrowout=0. After rst=1, in_ready=1, and a fresh 0x0003-0x0001 gives 0x0002.
- Back-to-back: in_valid and out_ready held at 1 for 100 random operand sets -> every result matches the reference model, and consecutive accepts are exactly NIB+2 cycles apart.
